// File: rtl/adder_4_bit_pkg.sv
// Shared definitions for the 4-bit ripple-carry adder slice.
//   WIDTH     : operand width (fixed at 4)
//   result_t  : bundle of the combinational adder result (sum, cout, ovf)
//   is_zero() : helper used to derive the registered zero flag
package adder_4_bit_pkg;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    return (value == '0);
  endfunction

endpackage

// File: rtl/adder_4_bit_if.sv
// Bundle of the registered-stage handshake of adder_4_bit.
//   in_valid  : qualifies the operands for capture
//   sum_q     : registered sum
//   cout_q    : registered carry out
//   ovf_q     : registered signed overflow
//   zero_q    : registered "sum was zero" flag
//   out_valid : registered in_valid
// master = side that issues operands, slave = the adder.
interface adder_4_bit_if;
  import adder_4_bit_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid;

  modport master (
    output in_valid,
    input  sum_q, cout_q, ovf_q, zero_q, out_valid
  );

  modport slave (
    input  in_valid,
    output sum_q, cout_q, ovf_q, zero_q, out_valid
  );

endinterface

// File: rtl/adder_4_bit_full_adder.sv
// One-bit full adder, the cell of the ripple chain.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_4_bit.sv
// 4-bit ripple-carry adder with a combinational result and a one-cycle
// registered copy.
//   A, B      : operands (unsigned; two's complement for Ovf)
//   Cin       : carry in
//   Sum, Cout : combinational A+B+Cin, bits [3:0] and bit 4
//   clk, rst  : clock and asynchronous active-high reset of the register stage
//   in_valid  : capture enable for the register stage
//   Ovf       : combinational two's-complement overflow
//   sum_q, cout_q, ovf_q, zero_q, out_valid : registered results
// The first five ports come first so positional hookup of just the
// combinational adder works with the rest left open.
module adder_4_bit
  import adder_4_bit_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             Ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
  logic [WIDTH:0] carry;
  result_t        res;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (res.sum[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign res.cout = carry[WIDTH];
  assign res.ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  assign Sum  = res.sum;
  assign Cout = res.cout;
  assign Ovf  = res.ovf;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Results hold while in_valid is low; only out_valid drops.
      if (in_valid) begin
        sum_q  <= res.sum;
        cout_q <= res.cout;
        ovf_q  <= res.ovf;
        zero_q <= is_zero(res.sum);
      end
    end
  end

endmodule

// File: tb/tb_adder_4_bit.sv
// Self-checking bench for adder_4_bit: combinational results are checked
// right after each input change; registered results go through a
// scoreboard queue popped by an independent monitor.
module tb_adder_4_bit;
  import adder_4_bit_pkg::*;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B, Sum;
  logic       Cin, Cout, Ovf;

  adder_4_bit_if bus ();

  adder_4_bit dut (
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sum       (Sum),
    .Cout      (Cout),
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .Ovf       (Ovf),
    .sum_q     (bus.sum_q),
    .cout_q    (bus.cout_q),
    .ovf_q     (bus.ovf_q),
    .zero_q    (bus.zero_q),
    .out_valid (bus.out_valid)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  // Hand-computed directed vectors.
  vec_t vecs[8] = '{
    '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1},
    '{4'b1100, 4'b1010, 1'b0, 4'b0110, 1'b1, 1'b1},
    '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0},
    '{4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0},
    '{4'b1110, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0},
    '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0},
    '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1},
    '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1}
  };

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies operands after a falling edge, checks the combinational
  // outputs, and queues the registered result when it will be captured.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic v, input logic [3:0] esum, input logic ecout,
                       input logic eovf);
    exp_t e;
    @(negedge clk);
    A = a; B = b; Cin = cin; bus.in_valid = v;
    #1;
    check("comb_sum",  {4'h0, Sum},  {4'h0, esum});
    check("comb_cout", {7'h0, Cout}, {7'h0, ecout});
    check("comb_ovf",  {7'h0, Ovf},  {7'h0, eovf});
    if (v && !rst) begin
      e.sum = esum; e.cout = ecout; e.ovf = eovf; e.zero = (esum == 4'h0);
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every presented registered result with the queue head.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {7'h0, bus.out_valid}, 8'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("reg_sum_q",  {4'h0, bus.sum_q},  {4'h0, e.sum});
        check("reg_cout_q", {7'h0, bus.cout_q}, {7'h0, e.cout});
        check("reg_ovf_q",  {7'h0, bus.ovf_q},  {7'h0, e.ovf});
        check("reg_zero_q", {7'h0, bus.zero_q}, {7'h0, e.zero});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    A = 4'b0101; B = 4'b0011; Cin = 1'b0;
    #1;
    check("rst_sum_q",     {4'h0, bus.sum_q},     8'h0);
    check("rst_cout_q",    {7'h0, bus.cout_q},    8'h0);
    check("rst_ovf_q",     {7'h0, bus.ovf_q},     8'h0);
    check("rst_zero_q",    {7'h0, bus.zero_q},    8'h0);
    check("rst_out_valid", {7'h0, bus.out_valid}, 8'h0);
    // Combinational path is live during reset.
    check("rst_comb_sum",  {4'h0, Sum},           8'h08);
    check("rst_comb_ovf",  {7'h0, Ovf},           8'h01);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back-to-back valid cycles.
    foreach (vecs[i])
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // Zero result, then idle: out_valid drops and the results hold.
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(4'b0011, 4'b0100, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("idle_out_valid", {7'h0, bus.out_valid}, 8'h0);
    check("idle_sum_hold",  {4'h0, bus.sum_q},     8'h0);
    check("idle_zero_hold", {7'h0, bus.zero_q},    8'h1);
    check("idle_cout_hold", {7'h0, bus.cout_q},    8'h0);

    // Reset between edges while out_valid is high.
    drive(4'b1110, 4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_sum_q",     {4'h0, bus.sum_q},     8'h0);
    check("midrst_cout_q",    {7'h0, bus.cout_q},    8'h0);
    check("midrst_ovf_q",     {7'h0, bus.ovf_q},     8'h0);
    check("midrst_zero_q",    {7'h0, bus.zero_q},    8'h0);
    check("midrst_out_valid", {7'h0, bus.out_valid}, 8'h0);
    check("midrst_comb_sum",  {4'h0, Sum},           8'h08);
    // A valid input under reset must not be captured (not queued).
    drive(4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst_no_capture", {7'h0, bus.out_valid}, 8'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive(4'b0010, 4'b0011, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);

    // Exhaustive sweep against an independent arithmetic model.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a, b;
      logic       c;
      logic [4:0] full;
      int         sa, sb_i, ss;
      a = i[3:0]; b = i[7:4]; c = i[8];
      full = {1'b0, a} + {1'b0, b} + {4'b0, c};
      sa   = a[3] ? int'(a) - 16 : int'(a);
      sb_i = b[3] ? int'(b) - 16 : int'(b);
      ss   = sa + sb_i + int'(c);
      drive(a, b, c, 1'b1, full[3:0], full[4], (ss > 7) || (ss < -8));
    end

    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb.size()), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
